uart_rx_fifo: RTL and testbench

- 8N1 UART receiver with a small first-word-fall-through byte FIFO.
- Sits directly upstream of scalable_proc. It deserialises the board ser_rx line and hands bytes to the processor core over a valid/ready handshake.
- Bit timing uses the same clocks-per-bit prescaler convention as the processor's UART_PRESCALER (100 MHz / 500 kbaud = 200).

---
 rtl/uart_rx_fifo.sv | 141 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small first-word-fall-through byte FIFO.
// RX is double-flopped; all frame timing counts clocks of the synchronised line.
module uart_rx_fifo #(
   parameter int  PRESCALER  = 200,
   parameter int  FIFO_DEPTH = 4,
   localparam int CW         = $clog2(PRESCALER),
   localparam int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          RX,
   output logic [7:0]    O_DATA,
   output logic          O_VALID,
   input  logic          O_READY,
   output logic          O_FRAME_ERR,
   output logic          O_OVERFLOW,
   output logic [AW:0]   O_COUNT
);

   localparam logic [CW-1:0] CNT_HALF = CW'(PRESCALER / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALER - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t        state;
   logic          rx_meta;
   logic          rx_s;
   logic [CW-1:0] cnt;
   logic [2:0]    bitidx;
   logic [7:0]    shreg;
   logic          frame_err;
   logic          overflow;

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          wr_en;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bitidx    <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state <= S_START;
                  cnt   <= '0;
               end
            end
            S_START: begin
               // A start bit must still be low half a bit in, else it was a glitch.
               if (cnt == CNT_HALF) begin
                  cnt    <= '0;
                  bitidx <= '0;
                  state  <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt    <= '0;
                  shreg  <= {rx_s, shreg[7:1]};
                  bitidx <= bitidx + 1'b1;
                  if (bitidx == 3'd7) state <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STOP: begin
               // Leave mid stop bit so a back-to-back start edge is not missed.
               if (cnt == CNT_LAST) begin
                  cnt       <= '0;
                  frame_err <= ~rx_s;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign push  = (state == S_STOP) && (cnt == CNT_LAST) && rx_s;
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (count == FULL_CNT);
   assign pop   = !empty && O_READY;
   assign wr_en = push && (!full || pop);

   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         overflow <= push && full && !pop;
      end
   end

   // Head byte is forced to zero while empty so the output is clean out of reset.
   assign O_DATA      = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
   assign O_VALID     = !empty;
   assign O_COUNT     = count;
   assign O_FRAME_ERR = frame_err;
   assign O_OVERFLOW  = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are driven bit by bit, expected bytes
// are queued at the write cycle and a negedge monitor checks the FIFO head and occupancy.
module tb_uart_rx_fifo;

   localparam int P     = 16;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   // Start edge to O_VALID: 2 sync flops, IDLE detect, half-bit qualify, 8 data bits, stop sample.
   localparam int LAT   = 9 * P + P / 2 + 3;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          RX = 1'b1;
   logic          O_READY = 1'b0;
   logic [7:0]    O_DATA;
   logic          O_VALID;
   logic          O_FRAME_ERR;
   logic          O_OVERFLOW;
   logic [AW:0]   O_COUNT;

   always #5 CLK = ~CLK;

   uart_rx_fifo #(.PRESCALER(P), .FIFO_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .RX(RX),
      .O_DATA(O_DATA), .O_VALID(O_VALID), .O_READY(O_READY),
      .O_FRAME_ERR(O_FRAME_ERR), .O_OVERFLOW(O_OVERFLOW), .O_COUNT(O_COUNT)
   );

   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         start_cyc = 0;
   int         rise_cyc = -1;
   int         valid_cycles = 0;
   int         exp_ferr = 0, got_ferr = 0;
   int         exp_ovf = 0, got_ovf = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] exp_q[$];
   bit         rand_done = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Monitor: FIFO head and occupancy must always agree with the expected-byte queue.
   always @(negedge CLK) begin
      if (RST !== 1'b1) begin
         prev_valid = 1'b0;
      end else begin
         check("count", 32'(O_COUNT), 32'(exp_q.size()));
         check("valid", 32'(O_VALID), 32'(exp_q.size() != 0));
         if (O_VALID === 1'b1) begin
            valid_cycles++;
            if (!prev_valid) rise_cyc = cyc;
            if (exp_q.size() != 0) begin
               check("data", 32'(O_DATA), 32'(exp_q[0]));
               if (O_READY === 1'b1) void'(exp_q.pop_front());
            end
         end
         prev_valid = O_VALID;
         if (O_FRAME_ERR === 1'b1) got_ferr++;
         if (O_OVERFLOW === 1'b1)  got_ovf++;
      end
   end

   // Drives one 8N1 frame. The reference decision is taken on the write cycle, so
   // occupancy already reflects any pop the consumer made on that same cycle.
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit pulse_ready);
      @(posedge CLK);
      #1 RX = 1'b0;
      start_cyc = cyc;
      repeat (P) @(posedge CLK);
      for (int i = 0; i < 8; i++) begin
         #1 RX = b[i];
         repeat (P) @(posedge CLK);
      end
      #1 RX = stop;
      repeat (P / 2 + 2) @(posedge CLK);
      if (pulse_ready) #1 O_READY = 1'b1;
      @(posedge CLK);
      #1;
      if (pulse_ready) O_READY = 1'b0;
      if (!stop)                     exp_ferr++;
      else if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                           exp_ovf++;
      repeat (P / 2 - 3) @(posedge CLK);
      #1 RX = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int fe_base, ov_base, v_base, d;
      logic [7:0] b;
      logic       stop;

      // Reset state
      repeat (3) @(posedge CLK);
      #1;
      check("rst_valid", 32'(O_VALID), 0);
      check("rst_data", 32'(O_DATA), 0);
      check("rst_count", 32'(O_COUNT), 0);
      check("rst_ferr", 32'(O_FRAME_ERR), 0);
      check("rst_ovf", 32'(O_OVERFLOW), 0);
      @(posedge CLK);
      #1 RST = 1'b1;
      idle(4);

      // Single byte, latency and one-cycle valid
      O_READY = 1'b1;
      v_base = valid_cycles;
      fe_base = got_ferr;
      send_frame(8'hA5, 1'b1, 1'b0);
      idle(4);
      d = rise_cyc - start_cyc;
      check_range("latency", d, LAT - 2, LAT + 2);
      check("a5_valid_cycles", 32'(valid_cycles - v_base), 1);
      check("a5_ferr", 32'(got_ferr - fe_base), 0);

      // Fill past capacity, then drain on consecutive cycles
      O_READY = 1'b0;
      ov_base = got_ovf;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
      idle(2);
      check("fill_count", 32'(O_COUNT), 4);
      check("fill_ovf_once", 32'(got_ovf - ov_base), 1);
      check("fill_ovf_model", 32'(got_ovf), 32'(exp_ovf));
      O_READY = 1'b1;
      idle(4);
      check("drain_count", 32'(O_COUNT), 0);
      check("drain_valid", 32'(O_VALID), 0);

      // Framing error then a good byte
      fe_base = got_ferr;
      v_base = valid_cycles;
      send_frame(8'h3C, 1'b0, 1'b0);
      idle(P);
      check("ferr_pulse", 32'(got_ferr - fe_base), 1);
      check("ferr_count", 32'(O_COUNT), 0);
      send_frame(8'h7E, 1'b1, 1'b0);
      idle(4);
      check("after_ferr_rx", 32'(valid_cycles - v_base), 1);

      // Short glitch while idle is ignored
      fe_base = got_ferr;
      v_base = valid_cycles;
      RX = 1'b0;
      idle(4);
      RX = 1'b1;
      idle(2 * P);
      check("glitch_valid", 32'(valid_cycles - v_base), 0);
      check("glitch_ferr", 32'(got_ferr - fe_base), 0);
      send_frame(8'h55, 1'b1, 1'b0);
      idle(4);
      check("after_glitch_rx", 32'(valid_cycles - v_base), 1);

      // Push into a full FIFO on the same cycle as a pop
      O_READY = 1'b0;
      ov_base = got_ovf;
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      send_frame(8'h33, 1'b1, 1'b0);
      send_frame(8'h44, 1'b1, 1'b0);
      idle(1);
      check("full_count", 32'(O_COUNT), 4);
      send_frame(8'h99, 1'b1, 1'b1);
      idle(1);
      check("pushpop_count", 32'(O_COUNT), 4);
      check("pushpop_ovf", 32'(got_ovf - ov_base), 0);
      O_READY = 1'b1;
      idle(5);
      check("pushpop_drain", 32'(O_COUNT), 0);

      // Asynchronous reset in the middle of a frame with bytes queued
      O_READY = 1'b0;
      send_frame(8'hA1, 1'b1, 1'b0);
      send_frame(8'hB2, 1'b1, 1'b0);
      idle(1);
      check("pre_rst_count", 32'(O_COUNT), 2);
      @(posedge CLK);
      #1 RX = 1'b0;
      b = 8'hF0;
      repeat (P) @(posedge CLK);
      for (int i = 0; i < 4; i++) begin
         #1 RX = b[i];
         repeat (P) @(posedge CLK);
      end
      repeat (P / 2) @(posedge CLK);
      @(negedge CLK);
      #2 RST = 1'b0;
      exp_q.delete();
      #1;
      check("async_rst_valid", 32'(O_VALID), 0);
      check("async_rst_count", 32'(O_COUNT), 0);
      RX = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      idle(4);
      O_READY = 1'b1;
      v_base = valid_cycles;
      send_frame(8'hC3, 1'b1, 1'b0);
      idle(4);
      check("after_rst_rx", 32'(valid_cycles - v_base), 1);

      // Randomised frames, gaps, glitches and consumer back-pressure
      fork
         begin
            while (!rand_done) begin
               @(posedge CLK);
               #1 O_READY = ($urandom_range(0, 3) != 0);
            end
         end
         begin
            for (int n = 0; n < 24; n++) begin
               if ($urandom_range(0, 5) == 0) begin
                  RX = 1'b0;
                  idle($urandom_range(1, P / 2 - 1));
                  RX = 1'b1;
                  idle(P + 4);
               end
               b = 8'($urandom);
               stop = ($urandom_range(0, 7) != 0);
               send_frame(b, stop, 1'b0);
               idle(stop ? $urandom_range(0, P) : P);
            end
            rand_done = 1'b1;
         end
      join
      O_READY = 1'b1;
      idle(10);
      check("rand_ferr", 32'(got_ferr), 32'(exp_ferr));
      check("rand_ovf", 32'(got_ovf), 32'(exp_ovf));
      check("rand_empty", 32'(O_COUNT), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
